mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM pipeline stage directly upstream of the write-back mux. Takes the EX result, performs load/store through a req/ack data-memory port and registers the MEM/WB pipeline values (Read_Data, alu_out, sel, destination info).
- Handles byte/half/word access with lane alignment and sign/zero extension.
- Stalls upstream while a memory access is outstanding.
- Flags misaligned, illegal and timed-out accesses.

Parameters:
- TIMEOUT, 16, cycles in WAIT_ACK without mem_ack before the access is aborted (must be ≥1).
- CNT_W, $clog2(TIMEOUT+1), width of the timeout counter (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX presents an instruction
- ex_alu_out  in  32  ALU result / memory address
- ex_store_data  in  32  store source register value
- ex_mem_read  in  1  load instruction
- ex_mem_write  in  1  store instruction
- ex_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- ex_unsigned  in  1  zero-extend load when 1
- ex_reg_write  in  1  instruction writes rd
- ex_rd  in  5  destination register
- stall  out  1  EX must hold its ex_* inputs
- mem_req  out  1  memory request, held until ack or abort
- mem_we  out  1  1 = write
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- mem_rdata  in  32  read data, valid with mem_ack
- mem_ack  in  1  access complete
- wb_valid  out  1  MEM/WB register holds a valid instruction
- Read_Data  out  32  aligned, extended load data
- alu_out  out  32  registered ex_alu_out
- sel  out  1  0 = write back Read_Data, 1 = write back alu_out
- wb_reg_write  out  1  register-file write enable
- wb_rd  out  5  destination register
- mem_err  out  1  misaligned / illegal / timeout, valid with wb_valid

Behaviour:
- Reset: state IDLE. All outputs 0: stall, mem_req, mem_we, mem_addr, mem_wdata, mem_be, wb_valid, Read_Data, alu_out, sel, wb_reg_write, wb_rd, mem_err. Timeout counter 0.
- FSM states: IDLE and WAIT_ACK. stall = (state == WAIT_ACK). ex_* inputs are ignored while stall = 1.
- IDLE, ex_valid = 0: wb_valid <= 0 (bubble).
- IDLE, non-memory op (read = write = 0):
  - at the next edge: wb_valid <= 1, alu_out <= ex_alu_out, sel <= 1, wb_reg_write <= ex_reg_write, wb_rd <= ex_rd, mem_err <= 0.
  - Latency 1 cycle.
- IDLE, error check on memory ops. Error if any of:
  - read and write both set
  - size 11
  - half with addr[0] = 1
  - word with addr[1:0] != 0
- IDLE, memory-op error:
  - no request is issued.
  - next edge: wb_valid <= 1, mem_err <= 1, wb_reg_write <= 0.
- IDLE, legal memory op:
  - latch rd, reg_write, size, unsigned, addr[1:0] and alu_out.
  - drive mem_addr, mem_we, mem_be, mem_wdata; mem_req <= 1; counter <= 0; go to WAIT_ACK; wb_valid <= 0.
- Byte enables: byte = 0001 << addr[1:0]; half = 0011 or 1100 by addr[1]; word = 1111.
- Write data: byte replicated ×4, half replicated ×2, word as-is.
- WAIT_ACK, mem_ack = 1 (ack in the first req cycle is legal):
  - next edge: mem_req <= 0, state IDLE, wb_valid <= 1 for one cycle, mem_err <= 0.
  - load: sel <= 0, Read_Data <= lane extract of mem_rdata, sign- or zero-extended.
  - store: sel <= 1, wb_reg_write <= 0.
  - Minimum memory-op latency: 2 cycles from acceptance to wb_valid.
- WAIT_ACK, no ack: counter increments. When counter reaches TIMEOUT-1 without ack:
  - mem_req <= 0, state IDLE.
  - wb_valid <= 1, mem_err <= 1, wb_reg_write <= 0.
  - If ack coincides with the terminal count, the ack wins.
- mem_ack while in IDLE is ignored.
- rst while in WAIT_ACK: next edge IDLE, mem_req 0, in-flight op dropped with no wb_valid.
- mem_addr, mem_we, mem_be and mem_wdata hold stable while mem_req = 1.

Decomposition:
- Shared package mem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - WB_SEL_MEM = 1'b0, WB_SEL_ALU = 1'b1 (shared with the write-back mux)
  - state enum {IDLE, WAIT_ACK}
- One sub-module, load_align, is natural: combinational lane select and extension taking mem_rdata, addr[1:0], size and unsigned.

Test Plan:
- Non-memory op: ex_alu_out = 0x0000_1234, rd = 5, reg_write = 1 -> next cycle wb_valid = 1, sel = 1, alu_out = 0x1234, wb_rd = 5, stall never high.
- Signed byte load: addr = 0x103, mem_rdata = 0x80FF_0000, ack on the first req cycle -> mem_be = 1000, Read_Data = 0xFFFF_FF80, sel = 0, wb_valid 2 cycles after acceptance. Same access with unsigned = 1 -> Read_Data = 0x0000_0080.
- Half store: addr = 0x202, data = 0x0000_ABCD, ack after 3 cycles -> mem_addr = 0x200, mem_be = 1100, mem_wdata = 0xABCD_ABCD, stall high 4 cycles, wb_reg_write = 0.
- Misaligned word load at addr 0x101 -> mem_req stays 0, next cycle wb_valid = 1, mem_err = 1, wb_reg_write = 0.
- No ack with TIMEOUT = 16 -> mem_req high exactly 16 cycles, then wb_valid = 1, mem_err = 1. Also an ack on the 16th cycle -> normal completion, mem_err = 0.
- rst asserted 2 cycles into WAIT_ACK, then a late ack -> mem_req 0 after reset, no wb_valid, late ack ignored.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage and the write-back mux.
// Size encodings, write-back select values, FSM states and lane helpers.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic WB_SEL_MEM = 1'b0;
    localparam logic WB_SEL_ALU = 1'b1;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    // Reserved size or an address not aligned to the access size.
    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] a
    );
        logic r;
        r = 1'b0;
        unique case (1'b1)
            size == SZ_BYTE: r = 1'b0;
            size == SZ_HALF: r = a[0];
            size == SZ_WORD: r = (a != 2'b00);
            default:         r = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] lane_be(
        input logic [1:0] size,
        input logic [1:0] a
    );
        logic [3:0] be;
        be = 4'b1111;
        unique case (1'b1)
            size == SZ_BYTE: be = 4'b0001 << a;
            size == SZ_HALF: be = a[1] ? 4'b1100 : 4'b0011;
            default:         be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate narrow store data across every lane it could land in.
    function automatic logic [31:0] lane_wdata(
        input logic [1:0]  size,
        input logic [31:0] d
    );
        logic [31:0] w;
        w = d;
        unique case (1'b1)
            size == SZ_BYTE: w = {4{d[7:0]}};
            size == SZ_HALF: w = {2{d[15:0]}};
            default:         w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load lane selection and sign/zero extension.
// Purely combinational; operates on the word returned by memory.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] data
);

    logic [31:0] shifted;
    logic [15:0] half;
    logic        sb;
    logic        sh;

    // Pick the addressed lane and extend it to 32 bits.
    always_comb begin
        shifted = rdata >> {addr, 3'b000};
        half    = addr[1] ? rdata[31:16] : rdata[15:0];
        sb      = ~uns & shifted[7];
        sh      = ~uns & half[15];
        data    = rdata;
        unique case (1'b1)
            size == SZ_BYTE: data = {{24{sb}}, shifted[7:0]};
            size == SZ_HALF: data = {{16{sh}}, half};
            default:         data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory access over req/ack and MEM/WB register.
// Holds EX while an access is outstanding and aborts stuck accesses.
module mem_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 16,
    localparam int CNT_W  = $clog2(TIMEOUT + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_out,
    input  logic [31:0] ex_store_data,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [1:0]  ex_size,
    input  logic        ex_unsigned,
    input  logic        ex_reg_write,
    input  logic [4:0]  ex_rd,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        wb_valid,
    output logic [31:0] Read_Data,
    output logic [31:0] alu_out,
    output logic        sel,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rd,
    output logic        mem_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       l_rd;
    logic             l_rw;
    logic             l_read;
    logic [1:0]       l_size;
    logic             l_uns;
    logic [1:0]       l_addr;
    logic [31:0]      l_alu;
    logic [31:0]      ld_data;
    logic             is_mem;
    logic             bad_op;

    assign stall  = (state == WAIT_ACK);
    assign is_mem = ex_mem_read | ex_mem_write;
    assign bad_op = (ex_mem_read & ex_mem_write)
                  | misaligned(ex_size, ex_alu_out[1:0]);

    load_align u_align (
        .rdata (mem_rdata),
        .addr  (l_addr),
        .size  (l_size),
        .uns   (l_uns),
        .data  (ld_data)
    );

    // Access FSM, memory port registers and MEM/WB pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_be       <= '0;
            wb_valid     <= 1'b0;
            Read_Data    <= '0;
            alu_out      <= '0;
            sel          <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd        <= '0;
            mem_err      <= 1'b0;
            l_rd         <= '0;
            l_rw         <= 1'b0;
            l_read       <= 1'b0;
            l_size       <= '0;
            l_uns        <= 1'b0;
            l_addr       <= '0;
            l_alu        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wb_valid <= 1'b0;
                    if (ex_valid && !is_mem) begin
                        wb_valid     <= 1'b1;
                        alu_out      <= ex_alu_out;
                        sel          <= WB_SEL_ALU;
                        wb_reg_write <= ex_reg_write;
                        wb_rd        <= ex_rd;
                        mem_err      <= 1'b0;
                    end else if (ex_valid && bad_op) begin
                        wb_valid     <= 1'b1;
                        alu_out      <= ex_alu_out;
                        sel          <= WB_SEL_ALU;
                        wb_reg_write <= 1'b0;
                        wb_rd        <= ex_rd;
                        mem_err      <= 1'b1;
                    end else if (ex_valid) begin
                        l_rd      <= ex_rd;
                        l_rw      <= ex_reg_write;
                        l_read    <= ex_mem_read;
                        l_size    <= ex_size;
                        l_uns     <= ex_unsigned;
                        l_addr    <= ex_alu_out[1:0];
                        l_alu     <= ex_alu_out;
                        mem_req   <= 1'b1;
                        mem_we    <= ex_mem_write;
                        mem_addr  <= {ex_alu_out[31:2], 2'b00};
                        mem_be    <= lane_be(ex_size, ex_alu_out[1:0]);
                        mem_wdata <= lane_wdata(ex_size, ex_store_data);
                        cnt       <= '0;
                        state     <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        state    <= IDLE;
                        wb_valid <= 1'b1;
                        mem_err  <= 1'b0;
                        alu_out  <= l_alu;
                        wb_rd    <= l_rd;
                        if (l_read) begin
                            sel          <= WB_SEL_MEM;
                            Read_Data    <= ld_data;
                            wb_reg_write <= l_rw;
                        end else begin
                            sel          <= WB_SEL_ALU;
                            wb_reg_write <= 1'b0;
                        end
                    end else if (cnt == CNT_LAST) begin
                        mem_req      <= 1'b0;
                        state        <= IDLE;
                        wb_valid     <= 1'b1;
                        mem_err      <= 1'b1;
                        wb_reg_write <= 1'b0;
                        alu_out      <= l_alu;
                        wb_rd        <= l_rd;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage against a byte-lane arithmetic model.
// Directed cases first, then randomized memory traffic.
module tb_mem_stage;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_alu_out;
    logic [31:0] ex_store_data;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [1:0]  ex_size;
    logic        ex_unsigned;
    logic        ex_reg_write;
    logic [4:0]  ex_rd;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        wb_valid;
    logic [31:0] Read_Data;
    logic [31:0] alu_out;
    logic        sel;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic        mem_err;

    int total = 0;
    int bad   = 0;

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_alu_out    (ex_alu_out),
        .ex_store_data (ex_store_data),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_size       (ex_size),
        .ex_unsigned   (ex_unsigned),
        .ex_reg_write  (ex_reg_write),
        .ex_rd         (ex_rd),
        .stall         (stall),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_be        (mem_be),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .wb_valid      (wb_valid),
        .Read_Data     (Read_Data),
        .alu_out       (alu_out),
        .sel           (sel),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .mem_err       (mem_err)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog obs=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    function automatic logic m_err(input logic rd, input logic wr,
                                   input logic [1:0] sz,
                                   input logic [31:0] a);
        if (rd && wr) return 1'b1;
        if (sz == 2'd3) return 1'b1;
        return (a % nbytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz,
                                        input logic [31:0] a);
        int v;
        v = ((1 << nbytes(sz)) - 1) << (a % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz,
                                            input logic [31:0] d);
        logic [63:0] x;
        if (sz == 2'd0) x = 64'(d % 256) * 64'h0101_0101;
        else if (sz == 2'd1) x = 64'(d % 65536) * 64'h0001_0001;
        else x = 64'(d);
        return x[31:0];
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rdata,
                                           input logic [31:0] a,
                                           input logic [1:0] sz,
                                           input logic uns);
        logic [63:0] mask;
        logic [63:0] v;
        int bits;
        bits = 8 * nbytes(sz);
        mask = (64'd1 << bits) - 64'd1;
        v    = (64'(rdata) >> (8 * (a % 4))) & mask;
        if (!uns && v[bits-1]) v = v | (~mask);
        return v[31:0];
    endfunction

    // One instruction through the stage; ack_dly < 0 means never ack.
    task automatic op(input logic rd, input logic wr, input logic [1:0] sz,
                      input logic uns, input logic [31:0] a,
                      input logic [31:0] sd, input logic rw,
                      input logic [4:0] rdst, input int ack_dly,
                      input logic [31:0] rdata);
        logic is_mem;
        logic err;
        logic tmo;
        int   n;
        is_mem        = rd | wr;
        err           = is_mem && m_err(rd, wr, sz, a);
        ex_valid      = 1'b1;
        ex_mem_read   = rd;
        ex_mem_write  = wr;
        ex_size       = sz;
        ex_unsigned   = uns;
        ex_alu_out    = a;
        ex_store_data = sd;
        ex_reg_write  = rw;
        ex_rd         = rdst;
        @(posedge clk); #1;
        ex_valid      = is_mem && !err;
        ex_alu_out    = $urandom;
        ex_store_data = $urandom;
        ex_rd         = 5'($urandom);
        ex_mem_read   = 1'($urandom);
        ex_mem_write  = 1'($urandom);
        if (!is_mem || err) begin
            chk("wb_valid", 32'(wb_valid), 32'd1);
            chk("mem_err", 32'(mem_err), 32'(err));
            chk("wb_reg_write", 32'(wb_reg_write), err ? 32'd0 : 32'(rw));
            chk("wb_rd", 32'(wb_rd), 32'(rdst));
            chk("stall_idle", 32'(stall), 32'd0);
            chk("mem_req_idle", 32'(mem_req), 32'd0);
            if (!is_mem) begin
                chk("sel_alu", 32'(sel), 32'd1);
                chk("alu_out", alu_out, a);
            end
        end else begin
            tmo = !(ack_dly >= 0 && ack_dly < TO);
            n   = tmo ? TO : ack_dly + 1;
            for (int c = 0; c < n; c++) begin
                chk("stall_wait", 32'(stall), 32'd1);
                chk("mem_req", 32'(mem_req), 32'd1);
                chk("mem_addr", mem_addr, a & ~32'd3);
                chk("mem_we", 32'(mem_we), 32'(wr));
                chk("mem_be", 32'(mem_be), 32'(m_be(sz, a)));
                chk("mem_wdata", mem_wdata, m_wdata(sz, sd));
                chk("wb_valid_wait", 32'(wb_valid), 32'd0);
                if (c == ack_dly) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end
                @(posedge clk); #1;
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end
            ex_valid = 1'b0;
            chk("mem_req_done", 32'(mem_req), 32'd0);
            chk("stall_done", 32'(stall), 32'd0);
            chk("wb_valid_done", 32'(wb_valid), 32'd1);
            chk("mem_err_done", 32'(mem_err), 32'(tmo));
            chk("wb_rd_done", 32'(wb_rd), 32'(rdst));
            chk("alu_out_done", alu_out, a);
            if (tmo) begin
                chk("wb_reg_write_tmo", 32'(wb_reg_write), 32'd0);
            end else if (rd) begin
                chk("sel_mem", 32'(sel), 32'd0);
                chk("Read_Data", Read_Data, m_load(rdata, a, sz, uns));
                chk("wb_reg_write_ld", 32'(wb_reg_write), 32'(rw));
            end else begin
                chk("sel_st", 32'(sel), 32'd1);
                chk("wb_reg_write_st", 32'(wb_reg_write), 32'd0);
            end
        end
        ex_valid = 1'b0;
        @(posedge clk); #1;
        chk("bubble", 32'(wb_valid), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        ex_valid      = 1'b0;
        ex_alu_out    = '0;
        ex_store_data = '0;
        ex_mem_read   = 1'b0;
        ex_mem_write  = 1'b0;
        ex_size       = '0;
        ex_unsigned   = 1'b0;
        ex_reg_write  = 1'b0;
        ex_rd         = '0;
        mem_rdata     = '0;
        mem_ack       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_Read_Data", Read_Data, 32'd0);
        chk("rst_alu_out", alu_out, 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_mem_err", 32'(mem_err), 32'd0);
        rst = 1'b0;

        op(0, 0, 2'd2, 0, 32'h0000_1234, 32'h0, 1, 5'd5, 0, 32'h0);
        op(1, 0, 2'd0, 0, 32'h0000_0103, 32'h0, 1, 5'd7, 0, 32'h80FF_0000);
        op(1, 0, 2'd0, 1, 32'h0000_0103, 32'h0, 1, 5'd7, 0, 32'h80FF_0000);
        op(0, 1, 2'd1, 0, 32'h0000_0202, 32'h0000_ABCD, 1, 5'd3, 3, 32'h0);
        op(1, 0, 2'd2, 0, 32'h0000_0101, 32'h0, 1, 5'd9, 0, 32'h0);
        op(1, 0, 2'd3, 0, 32'h0000_0100, 32'h0, 1, 5'd9, 0, 32'h0);
        op(1, 1, 2'd2, 0, 32'h0000_0100, 32'h0, 1, 5'd9, 0, 32'h0);
        op(1, 0, 2'd2, 0, 32'h0000_0400, 32'h0, 1, 5'd4, -1, 32'h0);
        op(1, 0, 2'd2, 0, 32'h0000_0404, 32'h0, 1, 5'd4, TO - 1, 32'hDEAD_BEEF);
        op(1, 0, 2'd1, 0, 32'h0000_0406, 32'h0, 1, 5'd6, 1, 32'h8001_1234);

        // Reset two cycles into an access, then a stray late ack.
        ex_valid     = 1'b1;
        ex_mem_read  = 1'b1;
        ex_mem_write = 1'b0;
        ex_size      = 2'd2;
        ex_alu_out   = 32'h0000_0800;
        ex_rd        = 5'd1;
        ex_reg_write = 1'b1;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        chk("rstw_req", 32'(mem_req), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstw_req_off", 32'(mem_req), 32'd0);
        chk("rstw_stall", 32'(stall), 32'd0);
        chk("rstw_wb_valid", 32'(wb_valid), 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk("late_ack_wb_valid", 32'(wb_valid), 32'd0);
        chk("late_ack_req", 32'(mem_req), 32'd0);
        chk("late_ack_stall", 32'(stall), 32'd0);

        for (int i = 0; i < 150; i++) begin
            int          k;
            int          dly;
            logic [1:0]  sz;
            logic [31:0] a;
            k  = int'($urandom_range(0, 7));
            sz = 2'($urandom);
            a  = $urandom;
            if ($urandom_range(0, 3) != 0 && sz != 2'd3)
                a = a & ~(32'(nbytes(sz)) - 32'd1);
            dly = ($urandom_range(0, 9) == 0)
                ? int'($urandom_range(TO - 2, TO + 2))
                : int'($urandom_range(0, 5));
            op(k >= 1 && k <= 3 || k == 7, k >= 4, sz, 1'($urandom), a,
               $urandom, 1'($urandom), 5'($urandom), dly, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
